// File: rtl/uart_pkg.sv
// Shared definitions for the UART result-return path: serializer state
// encodings, the sync byte and the bytes-per-word counts. The word header
// is enabled by defining UART_TX_WORD_HDR_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_END   = 3'd3,
        S_GAP        = 3'd4
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE            = 8'hA5;
    localparam int         BYTES_PER_WORD_PLAIN = 4;
    localparam int         BYTES_PER_WORD_HDR   = 5;

endpackage

// File: rtl/uart_word_fifo.sv
// Circular DEPTH x 32 word FIFO with occupancy count, full/empty flags and a
// sticky overflow flag. The read data shows the head entry combinationally.
module uart_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     i_Clock,
    input  logic                     reset,
    input  logic                     i_Push,
    input  logic [31:0]              i_Data,
    input  logic                     i_Pop,
    output logic [31:0]              o_Data,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic                     o_Overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign o_Full  = (o_Count == (AW+1)'(DEPTH));
    assign o_Empty = (o_Count == '0);
    assign o_Data  = mem[rd_ptr];

    // A push into a full FIFO is dropped; popping the same edge does not rescue it.
    assign push_ok = i_Push && !o_Full;
    assign pop_ok  = i_Pop && !o_Empty;

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge i_Clock) begin
        if (push_ok)
            mem[wr_ptr] <= i_Data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   o_Count <= o_Count + 1'b1;
                2'b01:   o_Count <= o_Count - 1'b1;
                default: o_Count <= o_Count;
            endcase
            if (i_Push && o_Full)
                o_Overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_word_feeder.sv
// Buffers 32-bit result words and feeds them LSB-first, one byte at a time,
// into uart_tx, pacing each byte off the transmitter's active/done status.
// Define UART_TX_WORD_HDR_EN to prefix every word with the 0xA5 sync byte.
module uart_tx_word_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_Clock,
    input  logic                     reset,
    input  logic                     i_Wr_Valid,
    input  logic [31:0]              i_Wr_Data,
    output logic                     o_Wr_Ready,
    output logic                     o_Tx_DV,
    output logic [7:0]               o_Tx_Byte,
    input  logic                     i_Tx_Active,
    input  logic                     i_Tx_Done,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Busy,
    output logic                     o_Overflow
);

`ifdef UART_TX_WORD_HDR_EN
    localparam int BPW = BYTES_PER_WORD_HDR;
`else
    localparam int BPW = BYTES_PER_WORD_PLAIN;
`endif
    localparam logic [2:0] LAST_IDX = 3'(BPW - 1);

    tx_state_t   state;
    logic [31:0] shreg;      // bytes of the current word not yet issued
    logic [2:0]  byte_idx;
    logic [31:0] fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    // Only start a word when the transmitter is fully idle.
    assign pop        = (state == S_IDLE) && !fifo_empty && !i_Tx_Active && !i_Tx_Done;
    assign o_Wr_Ready = !fifo_full;
    assign o_Busy     = (state != S_IDLE);

    uart_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_Clock    (i_Clock),
        .reset      (reset),
        .i_Push     (i_Wr_Valid),
        .i_Data     (i_Wr_Data),
        .i_Pop      (pop),
        .o_Data     (fifo_rd),
        .o_Count    (o_Count),
        .o_Full     (fifo_full),
        .o_Empty    (fifo_empty),
        .o_Overflow (o_Overflow)
    );

    // Serializer: DV is raised on the edge entering S_ISSUE so it is high
    // exactly for the S_ISSUE cycle; the byte holds until the next DV.
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state     <= S_IDLE;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
            shreg     <= 32'h0;
            byte_idx  <= 3'd0;
        end else begin
            o_Tx_DV <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        byte_idx <= 3'd0;
`ifdef UART_TX_WORD_HDR_EN
                        o_Tx_Byte <= SYNC_BYTE;
                        shreg     <= fifo_rd;
`else
                        o_Tx_Byte <= fifo_rd[7:0];
                        shreg     <= {8'h00, fifo_rd[31:8]};
`endif
                        o_Tx_DV   <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (i_Tx_Active)
                        state <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (!i_Tx_Active)
                        state <= S_GAP;
                end
                S_GAP: begin
                    // Transmitter is back in idle once done drops.
                    if (!i_Tx_Done && !i_Tx_Active) begin
                        if (byte_idx == LAST_IDX) begin
                            state <= S_IDLE;
                        end else begin
                            byte_idx  <= byte_idx + 1'b1;
                            o_Tx_Byte <= shreg[7:0];
                            shreg     <= {8'h00, shreg[31:8]};
                            o_Tx_DV   <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Bench for uart_tx_word_feeder with a behavioral uart_tx stand-in
// (CLKS_PER_BIT = C: active for 10*C cycles, then done for 2 cycles).
module tb_uart_tx_word_feeder;

    localparam int C     = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_WORD_HDR_EN
    localparam int NB  = 5;
    localparam int HDR = 1;
`else
    localparam int NB  = 4;
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        wr_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic [3:0]  count;
    logic        busy;
    logic        overflow;
    logic        force_act = 1'b0;

    uart_tx_word_feeder #(.DEPTH(DEPTH)) dut (
        .i_Clock     (clk),
        .reset       (reset),
        .i_Wr_Valid  (wr_valid),
        .i_Wr_Data   (wr_data),
        .o_Wr_Ready  (wr_ready),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Count     (count),
        .o_Busy      (busy),
        .o_Overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-in
    logic m_active = 1'b0;
    logic m_done   = 1'b0;
    int   m_cnt    = 0;
    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
        end else if (m_active) begin
            if (m_cnt == 10*C-1) begin m_active <= 1'b0; m_done <= 1'b1; m_cnt <= 0; end
            else m_cnt <= m_cnt + 1;
        end else if (m_done) begin
            if (m_cnt == 1) begin m_done <= 1'b0; m_cnt <= 0; end
            else m_cnt <= m_cnt + 1;
        end else if (tx_dv) begin
            m_active <= 1'b1; m_cnt <= 0;
        end
    end
    assign tx_active = m_active | force_act;
    assign tx_done   = m_done;

    // Byte monitor; cycle k is the interval ending at edge k
    logic [7:0] byte_q[$];
    int         cyc_q[$];
    int         dv_viol = 0;
    always @(negedge clk) begin
        if (tx_dv) begin
            byte_q.push_back(tx_byte);
            cyc_q.push_back(cyc + 1);
            if (tx_active || tx_done) dv_viol <= dv_viol + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] stream_byte(input logic [31:0] w, input int k);
        logic [31:0] t;
        if (HDR == 1 && k == 0) return 8'hA5;
        t = w >> (8 * (k - HDR));
        return t[7:0];
    endfunction

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; wr_valid = 1'b0; force_act = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] w, output int n);
        @(negedge clk); wr_valid = 1'b1; wr_data = w;
        @(posedge clk); #1; n = cyc; wr_valid = 1'b0;
    endtask

    task automatic push_rdy(input logic [31:0] w);
        int n;
        int t;
        @(negedge clk);
        for (t = 0; t < 2000 && !wr_ready; t++) @(negedge clk);
        check("wait_ready", 32'(wr_ready), 32'd1);
        push(w, n);
    endtask

    task automatic wait_bytes(input int n, input int limit);
        for (int t = 0; t < limit && byte_q.size() < n; t++) @(posedge clk);
        #1;
        check("wait_bytes", 32'(byte_q.size() >= n), 32'd1);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b [4];
    } vec_t;
    vec_t tbl [4];

    function automatic logic [7:0] tbl_byte(input int i, input int k);
        if (HDR == 1 && k == 0) return 8'hA5;
        return tbl[i].b[k - HDR];
    endfunction

    initial begin
        int n, n2, base;
        logic [31:0] words [$];

        tbl[0].word = 32'h44332211; tbl[0].b = '{8'h11, 8'h22, 8'h33, 8'h44};
        tbl[1].word = 32'hDEADBEEF; tbl[1].b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        tbl[2].word = 32'h000000FF; tbl[2].b = '{8'hFF, 8'h00, 8'h00, 8'h00};
        tbl[3].word = 32'h80000001; tbl[3].b = '{8'h01, 8'h00, 8'h00, 8'h80};

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(wr_ready), 1);
        check("rst_dv", 32'(tx_dv), 0);
        check("rst_byte", 32'(tx_byte), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        @(negedge clk); reset = 1'b0;

        // Single words from the table
        for (int i = 0; i < 4; i++) begin
            base = byte_q.size();
            push(tbl[i].word, n);
            check("count_after_push", 32'(count), 1);
            wait_bytes(base + NB, NB * 60);
            if (byte_q.size() >= base + NB) begin
                check("first_dv_cycle", 32'(cyc_q[base]), 32'(n + 2));
                for (int k = 0; k < NB; k++) begin
                    check("tbl_byte", 32'(byte_q[base+k]), 32'(tbl_byte(i, k)));
                    if (k > 0)
                        check("dv_spacing", 32'(cyc_q[base+k] - cyc_q[base+k-1]), 32'(10*C + 4));
                end
            end
            repeat (10*C + 10) @(posedge clk); #1;
            check("idle_busy", 32'(busy), 0);
            check("idle_count", 32'(count), 0);
        end

        // Two words back to back: extra S_IDLE cycle between words
        base = byte_q.size();
        push(32'hA1B2C3D4, n);
        push(32'h0F1E2D3C, n2);
        wait_bytes(base + 2*NB, 2*NB*60);
        if (byte_q.size() >= base + 2*NB) begin
            check("word_gap", 32'(cyc_q[base+NB] - cyc_q[base+NB-1]), 32'(10*C + 5));
            for (int k = 0; k < NB; k++) begin
                check("b2b_w0", 32'(byte_q[base+k]), 32'(stream_byte(32'hA1B2C3D4, k)));
                check("b2b_w1", 32'(byte_q[base+NB+k]), 32'(stream_byte(32'h0F1E2D3C, k)));
            end
        end
        repeat (10*C + 10) @(posedge clk);

        // Overflow with the transmitter held busy
        do_reset();
        force_act = 1'b1;
        base = byte_q.size();
        for (int i = 0; i < 8; i++) begin
            push(32'h10000000 + 32'(i) * 32'h01010101, n);
            check("ovf_ready", 32'(wr_ready), (i < 7) ? 32'd1 : 32'd0);
        end
        check("ovf_count8", 32'(count), 8);
        check("ovf_flag_pre", 32'(overflow), 0);
        push(32'hBAD00009, n);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count_hold", 32'(count), 8);
        @(negedge clk); force_act = 1'b0;
        wait_bytes(base + 8*NB, 8*NB*60);
        if (byte_q.size() >= base + 8*NB)
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < NB; k++)
                    check("ovf_drain", 32'(byte_q[base + i*NB + k]),
                          32'(stream_byte(32'h10000000 + 32'(i) * 32'h01010101, k)));
        repeat (300) @(posedge clk); #1;
        check("ovf_no_ninth", 32'(byte_q.size()), 32'(base + 8*NB));
        check("ovf_sticky", 32'(overflow), 1);

        // Same-edge push/pop at count 3, then 20 words across pointer wrap
        do_reset();
        check("rst_clears_ovf", 32'(overflow), 0);
        force_act = 1'b1;
        base = byte_q.size();
        words.delete();
        for (int i = 0; i < 20; i++)
            words.push_back(32'h5A000000 | (32'(i) << 16) | (32'(i) << 8) | 32'(i + 1));
        for (int i = 0; i < 3; i++) push(words[i], n);
        check("se_count3", 32'(count), 3);
        @(negedge clk); force_act = 1'b0; wr_valid = 1'b1; wr_data = words[3];
        @(posedge clk); #1; wr_valid = 1'b0;
        check("se_count_hold", 32'(count), 3);
        check("se_busy", 32'(busy), 1);
        for (int i = 4; i < 20; i++) push_rdy(words[i]);
        wait_bytes(base + 20*NB, 20*NB*60);
        if (byte_q.size() >= base + 20*NB)
            for (int i = 0; i < 20; i++)
                for (int k = 0; k < NB; k++)
                    check("wrap_order", 32'(byte_q[base + i*NB + k]), 32'(stream_byte(words[i], k)));
        repeat (10*C + 10) @(posedge clk);

        // Reset during the second byte with 3 words still queued
        do_reset();
        force_act = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hC0DE0000 + 32'(i), n);
        @(negedge clk); force_act = 1'b0;
        base = byte_q.size();
        wait_bytes(base + 2, 4*60);
        repeat (5) @(posedge clk);
        check("mid_count3", 32'(count), 3);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_dv", 32'(tx_dv), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_ready", 32'(wr_ready), 1);
        @(negedge clk); reset = 1'b0;
        repeat (400) @(posedge clk); #1;
        check("mid_no_more_dv", 32'(byte_q.size()), 32'(base + 2));

        check("dv_never_while_busy", 32'(dv_viol), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
